// File: rtl/nanov_pkg.sv
// Shared definitions for the nanov bit-serial datapath: ALU op codes,
// default widths and the operand-inversion helper.
package nanov_pkg;

  localparam int XLEN     = 32;
  localparam int CNT_BITS = 5;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_SLT  = 3'd5;
  localparam logic [2:0] OP_SLTU = 3'd6;
  localparam logic [2:0] OP_EQ   = 3'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } alu_state_t;

  // Subtraction-style ops run a + ~b + 1, so rs2 is inverted and carry starts at 1.
  function automatic logic op_inverts_b(input logic [2:0] op_i);
    return (op_i == OP_SUB) || (op_i == OP_SLT) || (op_i == OP_SLTU) || (op_i == OP_EQ);
  endfunction

endpackage

// File: rtl/nanov_serial_addbit.sv
// Single-bit combinational full adder, shared by the serial ALU and the
// PC incrementer.
module nanov_serial_addbit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/nanov_serial_alu.sv
// Bit-serial ALU stage: consumes LSB-first operand streams one bit per
// enabled clock and returns the result bit combinationally for rd.
module nanov_serial_alu
  import nanov_pkg::*;
#(
  parameter int XLEN     = nanov_pkg::XLEN,
  parameter int CNT_BITS = nanov_pkg::CNT_BITS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] op,
  input  logic       en,
  input  logic       data_rs1,
  input  logic       data_rs2,
  output logic       data_rd,
  output logic       rd_valid,
  output logic       busy,
  output logic       done,
  output logic       cmp_result
);

  alu_state_t          r_state;
  logic [2:0]          r_op;
  logic [CNT_BITS-1:0] r_cnt;
  logic                r_carry;
  logic                r_eq_acc;
  logic                r_done;
  logic                r_cmp;

  alu_state_t          w_state_nxt;
  logic [2:0]          w_op_nxt;
  logic [CNT_BITS-1:0] w_cnt_nxt;
  logic                w_carry_nxt;
  logic                w_eq_nxt;
  logic                w_done_nxt;
  logic                w_cmp_nxt;

  logic w_b;
  logic w_sum;
  logic w_cout;
  logic w_last;
  logic w_rd;

  assign w_b    = data_rs2 ^ op_inverts_b(r_op);
  assign w_last = (r_cnt == CNT_BITS'(XLEN - 1));

  nanov_serial_addbit u_addbit (
    .a    (data_rs1),
    .b    (w_b),
    .cin  (r_carry),
    .sum  (w_sum),
    .cout (w_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_op     <= OP_ADD;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_eq_acc <= 1'b1;
      r_done   <= 1'b0;
      r_cmp    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_op     <= w_op_nxt;
      r_cnt    <= w_cnt_nxt;
      r_carry  <= w_carry_nxt;
      r_eq_acc <= w_eq_nxt;
      r_done   <= w_done_nxt;
      r_cmp    <= w_cmp_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_cnt_nxt   = r_cnt;
    w_carry_nxt = r_carry;
    w_eq_nxt    = r_eq_acc;
    w_done_nxt  = 1'b0;
    w_cmp_nxt   = r_cmp;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
          w_op_nxt    = op;
          w_cnt_nxt   = '0;
          w_carry_nxt = op_inverts_b(op);
          w_eq_nxt    = 1'b1;
        end
      end
      ST_RUN: begin
        if (en) begin
          w_carry_nxt = w_cout;
          w_eq_nxt    = r_eq_acc & ~(data_rs1 ^ data_rs2);
          w_cnt_nxt   = r_cnt + 1'b1;
          if (w_last) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_done_nxt  = 1'b1;
            // On the MSB a differing sign decides SLT; equal signs defer to the difference sign.
            case (r_op)
              OP_EQ:          w_cmp_nxt = r_eq_acc & ~(data_rs1 ^ data_rs2);
              OP_SLTU, OP_SUB: w_cmp_nxt = ~w_cout;
              OP_SLT:         w_cmp_nxt = (data_rs1 != data_rs2) ? data_rs1 : w_sum;
              default:        w_cmp_nxt = r_cmp;
            endcase
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_rd = 1'b0;
    if (r_state == ST_RUN) begin
      case (r_op)
        OP_AND:                w_rd = data_rs1 & data_rs2;
        OP_OR:                 w_rd = data_rs1 | data_rs2;
        OP_XOR:                w_rd = data_rs1 ^ data_rs2;
        OP_SLT, OP_SLTU, OP_EQ: w_rd = 1'b0;
        default:               w_rd = w_sum;
      endcase
    end
  end

  assign data_rd    = w_rd;
  assign busy       = (r_state == ST_RUN);
  assign rd_valid   = busy & en;
  assign done       = r_done;
  assign cmp_result = r_cmp;

endmodule

// File: tb/tb_nanov_serial_alu.sv
// Self-checking bench for nanov_serial_alu: directed vector table, reset and
// start-while-busy sequences, then randomized ops against an arithmetic model.
module tb_nanov_serial_alu;
  import nanov_pkg::*;

  logic       clk;
  logic       rst;
  logic       start;
  logic [2:0] op;
  logic       en;
  logic       data_rs1;
  logic       data_rs2;
  logic       data_rd;
  logic       rd_valid;
  logic       busy;
  logic       done;
  logic       cmp_result;

  int n_checks = 0;
  int n_errors = 0;
  int stall_before [32];
  logic m_cmp;

  nanov_serial_alu dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .en         (en),
    .data_rs1   (data_rs1),
    .data_rs2   (data_rs2),
    .data_rd    (data_rd),
    .rd_valid   (rd_valid),
    .busy       (busy),
    .done       (done),
    .cmp_result (cmp_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          s1_bit;
    int          s1_len;
    int          s2_bit;
    int          s2_len;
    logic [31:0] exp_rd;
    logic        exp_cmp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: whole-word arithmetic, returns {cmp, rd}.
  function automatic logic [32:0] model(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input logic prev);
    logic [31:0] rd;
    logic        c;
    rd = '0;
    c  = prev;
    case (o)
      OP_ADD:  rd = a + b;
      OP_SUB:  begin rd = a - b; c = (a < b); end
      OP_AND:  rd = a & b;
      OP_OR:   rd = a | b;
      OP_XOR:  rd = a ^ b;
      OP_SLT:  c = ($signed(a) < $signed(b));
      OP_SLTU: c = (a < b);
      default: c = (a == b);
    endcase
    return {c, rd};
  endfunction

  function automatic int stall_total();
    int s = 0;
    for (int k = 0; k < 32; k++) s += stall_before[k];
    return s;
  endfunction

  // Called just after a rising edge; returns just after the edge that raises done.
  task automatic run_op(input logic [2:0] f_op, input logic [31:0] a, input logic [31:0] b,
                        input int poke_bit, output logic [31:0] res, output int lat);
    int   i;
    int   cyc;
    int   stl;
    logic flow_bad;
    res = '0; i = 0; cyc = 0; stl = 0; flow_bad = 1'b0;
    start = 1'b1; op = f_op; en = 1'($urandom_range(0, 1));
    data_rs1 = 1'($urandom); data_rs2 = 1'($urandom);
    @(posedge clk); #1;
    start = 1'b0;
    while (i < 32 && cyc < 200) begin
      if (stl < stall_before[i]) begin
        en = 1'b0; stl++;
      end else begin
        en = 1'b1;
      end
      data_rs1 = a[i];
      data_rs2 = b[i];
      if (i == poke_bit && en) begin
        start = 1'b1;
        op    = OP_ADD;
      end
      @(negedge clk);
      if (rd_valid !== en || busy !== 1'b1 || done !== 1'b0) flow_bad = 1'b1;
      if (en) res[i] = data_rd;
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (en) begin i++; stl = 0; end
    end
    lat = cyc;
    chk("run_flow", {31'd0, flow_bad}, 32'd0);
    chk("done_pulse", {30'd0, done, busy}, 32'd2);
  endtask

  vec_t        vecs [7];
  logic [31:0] res;
  logic [32:0] exp_m;
  int          lat;
  logic        saw_done;

  initial begin
    vecs[0] = '{OP_ADD,  32'h0000_0005, 32'h0000_0003, -1, 0, -1, 0, 32'h0000_0008, 1'b0};
    vecs[1] = '{OP_SUB,  32'h0000_0000, 32'h0000_0001, -1, 0, -1, 0, 32'hFFFF_FFFF, 1'b1};
    vecs[2] = '{OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, -1, 0, -1, 0, 32'h0000_0000, 1'b1};
    vecs[3] = '{OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, -1, 0, -1, 0, 32'h0000_0000, 1'b0};
    vecs[4] = '{OP_EQ,   32'h8000_0001, 32'h8000_0001, -1, 0, -1, 0, 32'h0000_0000, 1'b1};
    vecs[5] = '{OP_EQ,   32'h8000_0001, 32'h8002_0001, -1, 0, -1, 0, 32'h0000_0000, 1'b0};
    vecs[6] = '{OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 10, 3, 31, 1, 32'h8000_0000, 1'b0};

    rst = 1'b1; start = 1'b0; op = OP_ADD; en = 1'b0; data_rs1 = 1'b0; data_rs2 = 1'b0;
    for (int k = 0; k < 32; k++) stall_before[k] = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {28'd0, busy, done, cmp_result, rd_valid}, 32'd0);
    rst = 1'b0; en = 1'b1; data_rs1 = 1'b1; data_rs2 = 1'b1;
    @(negedge clk);
    chk("idle_outputs", {30'd0, data_rd, rd_valid}, 32'd0);
    @(posedge clk); #1;

    // Directed table, issued back-to-back (start lands on the done cycle).
    for (int v = 0; v < 7; v++) begin
      for (int k = 0; k < 32; k++) stall_before[k] = 0;
      if (vecs[v].s1_bit >= 0) stall_before[vecs[v].s1_bit] = vecs[v].s1_len;
      if (vecs[v].s2_bit >= 0) stall_before[vecs[v].s2_bit] = vecs[v].s2_len;
      run_op(vecs[v].op, vecs[v].a, vecs[v].b, -1, res, lat);
      chk($sformatf("vec%0d_rd", v), res, vecs[v].exp_rd);
      chk($sformatf("vec%0d_cmp", v), {31'd0, cmp_result}, {31'd0, vecs[v].exp_cmp});
      chk($sformatf("vec%0d_latency", v), lat, 32 + vecs[v].s1_len + vecs[v].s2_len);
    end
    for (int k = 0; k < 32; k++) stall_before[k] = 0;

    en = 1'b0;
    @(posedge clk); #1;
    chk("done_one_cycle", {30'd0, done, cmp_result}, 32'd0);

    // Set cmp_result, then abort an ADD at bit 16 with rst and start both high.
    run_op(OP_SUB, 32'h0, 32'h1, -1, res, lat);
    chk("pre_rst_cmp", {31'd0, cmp_result}, 32'd1);
    start = 1'b1; op = OP_ADD;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      en = 1'b1; data_rs1 = 1'b1; data_rs2 = 1'b1;
      @(posedge clk); #1;
    end
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    chk("mid_rst", {29'd0, busy, done, cmp_result}, 32'd0);
    saw_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    chk("no_done_after_rst", {31'd0, saw_done}, 32'd0);

    run_op(OP_XOR, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 5, res, lat);
    chk("xor_after_rst", res, 32'h5555_5555);
    chk("busy_start_ignored", {31'd0, cmp_result}, 32'd0);
    m_cmp = 1'b0;

    // Randomized ops with random stalls against the whole-word model.
    for (int t = 0; t < 24; t++) begin
      logic [2:0]  r_op;
      logic [31:0] a;
      logic [31:0] b;
      r_op = 3'($urandom_range(0, 7));
      a    = $urandom;
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a ^ (32'h1 << $urandom_range(0, 31));
        default: b = $urandom;
      endcase
      for (int k = 0; k < 32; k++)
        stall_before[k] = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
      exp_m = model(r_op, a, b, m_cmp);
      run_op(r_op, a, b, -1, res, lat);
      chk($sformatf("rnd%0d_op%0d_rd", t, r_op), res, exp_m[31:0]);
      chk($sformatf("rnd%0d_op%0d_cmp", t, r_op), {31'd0, cmp_result}, {31'd0, exp_m[32]});
      chk($sformatf("rnd%0d_latency", t), lat, 32 + stall_total());
      m_cmp = exp_m[32];
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/nanov_serial_alu.md
Name: nanov_serial_alu

Overview:
Bit-serial 32-bit ALU stage directly downstream of the serial register file.
- Consumes the LSB-first rs1/rs2 bit streams, one bit per clock.
- Returns a result bit stream that feeds the register file's rd write input in the same cycle.
- Also produces a registered comparison flag (EQ/SLT/SLTU) for the branch/SLT logic.
- One operation spans XLEN enabled clocks. Operations pause when the core stalls.

Parameters:
XLEN, 32, operand width in bits; number of enabled cycles per operation.
CNT_BITS, 5, bit-counter width; equals log2(XLEN).

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous reset, active-high
start  input  1  one-cycle request; latches op when idle
op  input  3  operation; encoding from the shared package
en  input  1  bit-advance enable; low = stall, all state held
data_rs1  input  1  operand A bit, LSB first
data_rs2  input  1  operand B bit, LSB first
data_rd  output  1  result bit for the register-file write port
rd_valid  output  1  high when data_rd is a meaningful bit (busy & en)
busy  output  1  operation in progress
done  output  1  one-cycle pulse, the clock after the last bit is consumed
cmp_result  output  1  registered compare outcome of the last EQ/SLT/SLTU/SUB operation

Behaviour:
- Reset values: busy=0, done=0, cmp_result=0, bit counter=0, carry=0, eq_acc=1, state IDLE. data_rd and rd_valid read 0 while not busy.
- States:
  - IDLE: start=1 → RUN. Latch op. counter=0. carry=1 for SUB/SLT/SLTU/EQ, else 0. eq_acc=1.
  - RUN: bit 0 is presented on the first RUN cycle with en=1. The start cycle itself consumes no data.
  - RUN, en=0: counter, carry, eq_acc and op all hold. data_rd keeps computing from the current inputs but rd_valid=0.
  - RUN, en=1: consume one bit.
    - b' = data_rs2 ^ inv, where inv=1 for SUB/SLT/SLTU/EQ.
    - ADD/SUB: data_rd = a^b'^carry. carry_next = maj(a,b',carry).
    - AND/OR/XOR: data_rd = bitwise result; carry unused.
    - SLT/SLTU/EQ: data_rd = 0, so rd is written as zero-extended. The core inserts the flag into bit 0 via its own write path.
    - eq_acc &= ~(a ^ data_rs2). counter++.
  - RUN, en=1, counter==XLEN-1: last bit.
    - EQ: cmp_result = eq_acc & ~(a^b).
    - SLTU: cmp_result = ~carry_next.
    - SLT: cmp_result = (a!=b) ? a : sum, using bit 31 values.
    - SUB: cmp_result = carry-out inverted (borrow).
    - Other ops: cmp_result unchanged.
    - Next state IDLE, counter wraps to 0, done=1 for exactly one clock.
- done asserts even if en is low on that following clock.
- start while busy: ignored. No restart, no error.
- start in the same cycle done is high: accepted (the block is IDLE then). This gives back-to-back operations with one idle bubble.
- rst mid-operation: returns to IDLE next edge with the reset values above. No done pulse. cmp_result cleared.
- rst and start together: rst wins.
- Latency: operation complete XLEN enabled cycles after the first RUN cycle. cmp_result is valid from the edge that raises done and holds until the next compare op completes.
- Undefined op codes: behave as ADD for data_rd; cmp_result unchanged.

Decomposition:
- Shared package nanov_pkg holds:
  - ALU op localparams: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLTU=6, EQ=7.
  - XLEN/CNT_BITS defaults.
  - A helper function op_inverts_b(op).
- One natural sub-module: nanov_serial_addbit. It is a combinational full adder (a, b, cin → sum, cout), reused later by the PC incrementer.
- FSM, counter and compare accumulator stay in the top module.

Test Plan:
- ADD, A=0x0000_0005, B=0x0000_0003, en=1 throughout → serial data_rd assembles 0x0000_0008. done pulses exactly 33 clocks after start (1 start + 32 bits).
- SUB, A=0x0000_0000, B=0x0000_0001 → data_rd = 0xFFFF_FFFF, cmp_result=1 (borrow).
- SLT, A=0xFFFF_FFFF (−1), B=0x0000_0001 → data_rd all zeros, cmp_result=1. Same operands with SLTU → cmp_result=0.
- EQ, A=B=0x8000_0001 → cmp_result=1. Flip bit 17 of B only → cmp_result=0.
- ADD, A=0x7FFF_FFFF, B=1, en low for 3 cycles at bit 10 and 1 cycle at bit 31 → result 0x8000_0000 unchanged. rd_valid low during stalls. done delayed by exactly 4 clocks.
- Assert rst at bit 16 of an ADD → next cycle busy=0, done never pulses, cmp_result=0. A following start runs a fresh XOR 0xAAAA_AAAA^0xFFFF_FFFF = 0x5555_5555. Also issue start while busy → ignored, result unchanged.
